// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding an LSB-first serialiser.
// Each bit lasts clkdiv+1 clocks, and frames are sent back to back while the FIFO holds data.
module uart_tx #(
  parameter int unsigned clkdiv     = 50000000/115200-1,
  parameter int unsigned depth_log2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       overflow,
  output logic       tx_serial,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DEPTH = 1 << depth_log2;
  localparam logic [15:0] DIV = 16'(clkdiv);
  localparam logic [depth_log2:0] DEPTH_C = {1'b1, {depth_log2{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q;
  logic [7:0]            mem_q [DEPTH];
  logic [depth_log2-1:0] wptr_q, rptr_q;
  logic [depth_log2:0]   count_q, count_d;
  logic                  push, pop, bit_end, nonempty;

  // full is taken from the pre-pop count, so a write racing a pop at full is still dropped
  assign full      = (count_q == DEPTH_C);
  assign nonempty  = (count_q != '0);
  assign push      = wr_en && !full;
  assign bit_end   = (cnt_q == DIV);
  assign busy      = (state_q != IDLE);
  assign tx_serial = tx_q;
  assign overflow  = ovf_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done  = 1'b1;
          cnt_d = '0;
          // chain straight into the next start bit when more data is queued
          if (nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ovf_q   <= wr_en && full;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wptr_q] <= din;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter, 8N1, LSB first, the transmit-side counterpart to the receive path on the same serial link. It accepts bytes from the fabric through a small FIFO and serialises each as one start bit, eight data bits and one stop bit at a bit period of `clkdiv+1` clock cycles. It sits between the local byte producer and the `tx_serial` pad and holds the line idle-high whenever the FIFO is empty.

## Interface
- `clkdiv`, default `50000000/115200-1` (433): bit period minus one, in `clk` cycles; legal range 1..65535.
- `depth_log2`, default 2: FIFO holds `2**depth_log2` bytes (default 4).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-low: logic resets on a rising `clk` edge while `rst`=0.
- `din`  input  8  byte to transmit, sampled when `wr_en`=1 and `full`=0.
- `wr_en`  input  1  write strobe, one byte per cycle.
- `full`  output  1  FIFO full; writes are dropped while high.
- `overflow`  output  1  one-cycle pulse when `wr_en`=1 while `full`=1.
- `tx_serial`  output  1  serial line, registered, idle high.
- `busy`  output  1  high from first cycle of a start bit through last cycle of a stop bit.
- `done`  output  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- Reset values: `tx_serial`=1, `busy`=0, `done`=0, `full`=0, `overflow`=0; FIFO empty (pointers and count 0), state IDLE, bit counter 0, cycle counter 0.
- FIFO: write pointer, read pointer (`depth_log2` bits, wrap naturally), count (`depth_log2+1` bits). `full` = count==depth, combinational from count. Simultaneous accepted write and pop leaves count unchanged. Write into a full FIFO is dropped and never corrupts stored data, even if a pop happens in the same cycle (`full` is evaluated before the pop).
- States: IDLE, START, DATA, STOP.
  - IDLE: if count>0, pop head into 8-bit shift register, cycle counter←0, `tx_serial`←0, go START. Otherwise `tx_serial`←1.
  - START: cycle counter counts 0..`clkdiv`; at `clkdiv`, counter←0, `tx_serial`←shift[0], shift right, bit counter←0, go DATA.
  - DATA: at each counter==`clkdiv`, counter←0; if bit counter==7, `tx_serial`←1, go STOP; else bit counter+1, `tx_serial`←next shift[0], shift right.
  - STOP: at counter==`clkdiv`: `done` pulses (asserted during that cycle); if count>0, pop next byte, `tx_serial`←0, go START (no idle gap); else `tx_serial`←1, go IDLE.
- Cycle counter 16 bits; compare is equality with `clkdiv`, no wrap possible.
- `busy` = state≠IDLE.
- Reset asserted mid-frame: frame abandoned, line returns high on the reset edge, FIFO contents discarded.

## Timing
- Write accepted on edge E0; if IDLE, `tx_serial` falls on edge E1 (one-cycle latency).
- Each bit holds exactly `clkdiv+1` cycles; frame = 10·(`clkdiv+1`) cycles.
- Back-to-back bytes: next start bit begins the cycle immediately after the previous stop bit's last cycle; sustained throughput one byte per 10·(`clkdiv+1`) cycles.
- `done` high on the final cycle of STOP; `busy` falls one cycle later if FIFO empty.
- `overflow` high in the cycle following the dropped write edge? No: it is a registered pulse, high for exactly the one cycle after the rejected `wr_en` edge.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `wr_en`=1 -> `tx_serial`=1, `busy`=0, `full`=0, no frame after release.
- Single byte, `clkdiv`=3: write 0xA5 -> line low 1 cycle later, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, `done` pulse on cycle 40, `busy` low on cycle 41.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles -> two 40-cycle frames, second start bit immediately after first stop bit, two `done` pulses 40 cycles apart.
- Full/overflow, depth 4: write 6 bytes on consecutive cycles while IDLE -> first byte popped at cycle 1, bytes 2..5 fill FIFO, `full`=1, 6th write raises `overflow` one cycle, transmitted sequence is exactly bytes 1..5.
- Reset mid-frame: assert `rst`=0 during DATA bit 3 of 0x55 -> `tx_serial`=1 next edge, FIFO empty, no further output after release.
- Simultaneous write and pop at full: FIFO full, write at the STOP→START pop cycle -> write dropped, `overflow` pulses, count becomes depth−1.
